alu_seq: RTL

//  Sequential, width-parametrised successor of the combinational ALU: same 3-bit opcode map, registered

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_core.sv | 68 ++++++
 rtl/alu_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, flag bit positions,
// FSM state encoding and a small opcode-classification helper.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_XOR = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOR = 3'd4,
        OP_SL  = 3'd5,
        OP_SR  = 3'd6,
        OP_SUB = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Shift opcodes take the iterative path when their amount is non-zero.
    function automatic logic is_shift(input op_e op);
        return (op == OP_SL) || (op == OP_SR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops with {N,Z,C,V} flag generation.
// SL/SR pass A through unchanged (the zero-amount shift result); non-zero
// shifts are iterated in alu_seq.
// Optional feature: define ALU_SAT_EN to saturate ADD/SUB on signed overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;

    // Operation select plus carry/overflow for the arithmetic ops.
    always_comb begin
        sum  = {1'b0, a_i} + {1'b0, b_i};
        diff = {1'b0, a_i} - {1'b0, b_i};
        res  = a_i;
        c    = 1'b0;
        v    = 1'b0;
        case (op_e'(opcode_i))
            OP_ADD: begin
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                res = diff[MSB:0];
                c   = ~diff[WIDTH];   // no borrow <=> A >= B unsigned
                v   = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            OP_XOR:  res = a_i ^ b_i;
            OP_AND:  res = a_i & b_i;
            OP_OR:   res = a_i | b_i;
            OP_NOR:  res = ~(a_i | b_i);
            default: res = a_i;
        endcase
`ifdef ALU_SAT_EN
        // Overflow direction follows A's sign for both ADD and SUB.
        if (v) begin
            res = a_i[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Flags are taken from the final (possibly saturated) result.
    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_N] = res[MSB];
        flags_o[FLAG_Z] = (res == '0);
        flags_o[FLAG_C] = c;
        flags_o[FLAG_V] = v;
    end

    assign result_o = res;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready handshake on both sides, registered result and
// flags, multi-bit shifts executed one bit per cycle. One operation in flight.
// Optional feature: define ALU_SAT_EN for saturating ADD/SUB (see alu_core).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_r_q, dir_r_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         flags_q, flags_d;

    logic [WIDTH-1:0]   core_res;
    logic [3:0]         core_flags;
    logic               accept;
    logic               start_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sh_next;
    logic               sh_out;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .opcode_i (in_opcode),
        .a_i      (in_a),
        .b_i      (in_b),
        .result_o (core_res),
        .flags_o  (core_flags)
    );

    assign shamt       = in_b[SHAMT_W-1:0];
    assign accept      = in_valid & in_ready;
    assign start_shift = is_shift(op_e'(in_opcode)) && (shamt != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = start_shift ? ST_SHIFT : ST_RESP;
            end
            ST_SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (accept)         state_d = start_shift ? ST_SHIFT : ST_RESP;
                else if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; in_ready is forced low while reset is asserted.
    always_comb begin
        in_ready  = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && out_ready));
        out_valid = (state_q == ST_RESP);
        busy      = (state_q == ST_SHIFT);
    end

    // One-bit shift step and the bit it pushes out.
    always_comb begin
        if (dir_r_q) begin
            sh_next = sh_q >> 1;
            sh_out  = sh_q[0];
        end else begin
            sh_next = sh_q << 1;
            sh_out  = sh_q[WIDTH-1];
        end
    end

    // Datapath next-state: load on accept, iterate while shifting.
    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        dir_r_d = dir_r_q;
        res_d   = res_q;
        flags_d = flags_q;
        if (accept) begin
            if (start_shift) begin
                sh_d    = in_a;
                cnt_d   = shamt;
                dir_r_d = (op_e'(in_opcode) == OP_SR);
            end else begin
                res_d   = core_res;
                flags_d = core_flags;
            end
        end else if (state_q == ST_SHIFT) begin
            sh_d  = sh_next;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
                res_d           = sh_next;
                flags_d         = '0;
                flags_d[FLAG_N] = sh_next[WIDTH-1];
                flags_d[FLAG_Z] = (sh_next == '0);
                flags_d[FLAG_C] = sh_out;
            end
        end
    end

    // Datapath registers; reset drops any in-flight op and clears outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            dir_r_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dir_r_q <= dir_r_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign out_result = res_q;
    assign out_flags  = flags_q;

endmodule
